// File: rtl/sdram_test_pkg.sv
// Shared types and helpers for the SDRAM self-test sequencer.
package sdram_test_pkg;

  localparam int LFSR_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_e;

  // One step of the 8-bit pattern generator (taps at bits 2, 3 and 4 fed by bit 7).
  function automatic logic [LFSR_W-1:0] lfsr8_next(input logic [LFSR_W-1:0] d);
    logic [LFSR_W-1:0] n;
    n[0] = d[7];
    n[1] = d[0];
    n[2] = d[1] ^ d[7];
    n[3] = d[2] ^ d[7];
    n[4] = d[3] ^ d[7];
    n[5] = d[4];
    n[6] = d[5];
    n[7] = d[6];
    return n;
  endfunction

endpackage

// File: rtl/sdram_test_lfsr8.sv
// 8-bit pattern LFSR with reload-to-seed and single-step controls.
// Used twice by the sequencer: once to generate write data, once to predict read data.
module sdram_test_lfsr8
  import sdram_test_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED_VAL = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reload,
  input  logic              step,
  output logic [LFSR_W-1:0] data
);

  logic [LFSR_W-1:0] data_q;
  logic [LFSR_W-1:0] data_d;

  // Reload wins over step so a pass boundary always restarts the sequence cleanly.
  always_comb begin
    data_d = data_q;
    if (reload) begin
      data_d = SEED_VAL;
    end else if (step) begin
      data_d = lfsr8_next(data_q);
    end
  end

  // Pattern register; reset puts it back on the seed.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= SEED_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/sdram_test_sequencer.sv
// SDRAM self-test sequencer: writes an LFSR pattern over a word window, reads it
// back, and reports pass/fail, a saturating error count and the first bad address.
// Optional build macro SDRAM_TEST_ERR_INJECT_EN adds an err_inject input that flips
// bit 0 of the first written word so the compare path can be proven on the board.
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the last pass
// WRITE | issuing NUM_WORDS pattern writes
// READ  | issuing NUM_WORDS reads; returns are checked as they arrive
// DRAIN | all reads issued; waiting for the remaining returns
// DONE  | one-cycle done pulse; pass already reflects the final count
module sdram_test_sequencer
  import sdram_test_pkg::*;
#(
  parameter int ADDR_W    = 22,
  parameter int NUM_WORDS = 256,
  parameter int BASE_ADDR = 0,
  parameter int SEED      = 32,
  parameter int ERR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef SDRAM_TEST_ERR_INJECT_EN
  input  logic              err_inject,
`endif
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic              mem_read,
  output logic [7:0]        mem_writedata,
  input  logic              mem_waitrequest,
  input  logic [7:0]        mem_readdata,
  input  logic              mem_readdatavalid
);

  // Counters carry one extra bit so a full 2^ADDR_W window is countable.
  localparam int                CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  NUM_C   = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [LFSR_W-1:0] SEED_C  = LFSR_W'(SEED);
  localparam logic [ERR_W-1:0]  ERR_MAX = {ERR_W{1'b1}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   chk_cnt_q, chk_cnt_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [ADDR_W-1:0]  first_err_addr_q, first_err_addr_d;
  logic               pass_q, pass_d;

  logic               gen_reload, gen_step, chk_reload, chk_step;
  logic [LFSR_W-1:0]  gen_data, chk_data, wdata;
  logic               accept, issue_last, rd_valid;
  logic [ADDR_W-1:0]  req_addr;

  sdram_test_lfsr8 #(.SEED_VAL(SEED_C)) u_gen_lfsr (
    .clk    (clk),
    .reset  (reset),
    .reload (gen_reload),
    .step   (gen_step),
    .data   (gen_data)
  );

  sdram_test_lfsr8 #(.SEED_VAL(SEED_C)) u_chk_lfsr (
    .clk    (clk),
    .reset  (reset),
    .reload (chk_reload),
    .step   (chk_step),
    .data   (chk_data)
  );

  assign accept     = ((state_q == WRITE) || (state_q == READ)) && !mem_waitrequest;
  assign issue_last = (issue_cnt_q == LAST_C);
  assign rd_valid   = mem_readdatavalid && ((state_q == READ) || (state_q == DRAIN));
  assign req_addr   = BASE_C + issue_cnt_q[ADDR_W-1:0];

`ifdef SDRAM_TEST_ERR_INJECT_EN
  logic inj_q, inj_d;

  // Inject request is captured with start and only touches word 0 of the pass.
  always_comb begin
    inj_d = inj_q;
    if ((state_q == IDLE) && start) begin
      inj_d = err_inject;
    end
  end

  // Inject flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      inj_q <= 1'b0;
    end else begin
      inj_q <= inj_d;
    end
  end

  assign wdata = gen_data ^ {{(LFSR_W-1){1'b0}}, (inj_q && (issue_cnt_q == '0))};
`else
  assign wdata = gen_data;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the check count used here already includes this cycle's return.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = WRITE;
      WRITE:   if (accept && issue_last) state_d = READ;
      READ:    if (accept && issue_last) state_d = (chk_cnt_d == NUM_C) ? DONE : DRAIN;
      DRAIN:   if (chk_cnt_d == NUM_C) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: requests are decoded straight from state so they hold through stalls.
  always_comb begin
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_q)
      WRITE: begin
        mem_write     = 1'b1;
        mem_address   = req_addr;
        mem_writedata = wdata;
        busy          = 1'b1;
      end
      READ: begin
        mem_read    = 1'b1;
        mem_address = req_addr;
        busy        = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Issue/check counters, LFSR controls and the compare path.
  always_comb begin
    issue_cnt_d      = issue_cnt_q;
    chk_cnt_d        = chk_cnt_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    gen_reload       = 1'b0;
    gen_step         = 1'b0;
    chk_reload       = 1'b0;
    chk_step         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          issue_cnt_d      = '0;
          chk_cnt_d        = '0;
          err_count_d      = '0;
          first_err_addr_d = '0;
          gen_reload       = 1'b1;
          chk_reload       = 1'b1;
        end
      end
      WRITE: begin
        if (accept) begin
          if (issue_last) begin
            // Rewind the generator so the read phase sees the same sequence.
            issue_cnt_d = '0;
            gen_reload  = 1'b1;
          end else begin
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
            gen_step    = 1'b1;
          end
        end
      end
      READ: begin
        if (accept) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    if (rd_valid) begin
      if (mem_readdata != chk_data) begin
        if (err_count_q != ERR_MAX) begin
          err_count_d = err_count_q + ERR_W'(1);
        end
        // A zero count means this is the first mismatch of the pass.
        if (err_count_q == '0) begin
          first_err_addr_d = BASE_C + chk_cnt_q[ADDR_W-1:0];
        end
      end
      chk_step  = 1'b1;
      chk_cnt_d = chk_cnt_q + CNT_W'(1);
    end
  end

  // Pass flag: cleared when a pass begins, resolved on entry to DONE.
  always_comb begin
    pass_d = pass_q;
    if ((state_q == IDLE) && start) begin
      pass_d = 1'b0;
    end else if ((state_q != DONE) && (state_d == DONE)) begin
      pass_d = (err_count_d == '0);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt_q      <= '0;
      chk_cnt_q        <= '0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      pass_q           <= 1'b0;
    end else begin
      issue_cnt_q      <= issue_cnt_d;
      chk_cnt_q        <= chk_cnt_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      pass_q           <= pass_d;
    end
  end

  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;

endmodule

// File: doc/sdram_test_sequencer.md
Name: sdram_test_sequencer

Overview:
- Self-test traffic controller for the SDRAM controller example path.
- Writes an 8-bit LFSR pseudo-random pattern across a configurable address window, then reads the window back.
- Compares each returned word against a second, identically seeded LFSR and reports pass/fail, error count and first failing address.
- Sits between the board start button/status LEDs and the SDRAM controller's Avalon-style slave port.

Parameters:
- ADDR_W, 22, address width of the memory port in words.
- NUM_WORDS, 256, words tested per pass; legal range 1..2^ADDR_W.
- BASE_ADDR, 0, first word address tested.
- SEED, 32, LFSR seed; the low 8 bits are used.
- ERR_W, 16, width of the error counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a pass when idle.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when a pass completes.
- pass  out  1  result of the last pass: 1 means zero errors; held until the next start.
- err_count  out  ERR_W  mismatches in the last pass; saturates at all-ones.
- first_err_addr  out  ADDR_W  address of the first mismatch; valid when pass=0.
- mem_address  out  ADDR_W  word address.
- mem_write  out  1  write request.
- mem_read  out  1  read request.
- mem_writedata  out  8  write data.
- mem_waitrequest  in  1  slave stall; hold the request and its address/data while high.
- mem_readdata  in  8  read return data.
- mem_readdatavalid  in  1  read return strobe; multiple reads may be outstanding, and data returns in order.

Behaviour:
- Reset values: busy=0, done=0, pass=0, err_count=0, first_err_addr=0, mem_write=0, mem_read=0, mem_address=0, mem_writedata=0. Both LFSRs are set to SEED[7:0]. The FSM goes to IDLE.
- LFSR step (next from d): n0=d7, n1=d0, n2=d1^d7, n3=d2^d7, n4=d3^d7, n5=d4, n6=d5, n7=d6. From seed 0x20 the sequence is 0x20, 0x40, 0x80, 0x1D, ...
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - On start=1: reload both LFSRs to seed, clear err_count, set busy=1, set the issue counter to 0 and the check counter to 0.
  - Next state is WRITE.
  - start is ignored in every other state.
- WRITE:
  - Drive mem_write=1, mem_address=BASE_ADDR+issue counter, mem_writedata=gen LFSR.
  - A write is accepted in a cycle with mem_write=1 and mem_waitrequest=0. On acceptance, step the gen LFSR and increment the issue counter.
  - After NUM_WORDS acceptances: deassert mem_write in the next cycle, reload the gen LFSR to seed, reset the issue counter, and go to READ. There is no idle gap requirement.
- READ:
  - Drive mem_read=1, mem_address=BASE_ADDR+issue counter.
  - Acceptance uses the same rule as WRITE; increment the issue counter on each acceptance.
  - After NUM_WORDS acceptances go to DRAIN. If the check counter already equals NUM_WORDS, go directly to DONE.
  - mem_readdatavalid is processed in both READ and DRAIN.
- Check path, on each mem_readdatavalid:
  - Compare mem_readdata with the chk LFSR.
  - On mismatch: err_count = err_count + 1, saturating at all-ones. On the first mismatch of the pass, capture first_err_addr = BASE_ADDR + check counter.
  - Then step the chk LFSR and increment the check counter.
- DRAIN: once the check counter reaches NUM_WORDS, go to DONE.
- DONE: pulse done=1 for one cycle, set pass=(err_count==0), set busy=0, and return to IDLE.
  - pass and err_count reflect a valid returned on the same cycle as the transition into DONE.
- Address arithmetic is modulo 2^ADDR_W; BASE_ADDR+NUM_WORDS beyond the top of the space wraps to 0.
- Counters are ADDR_W+1 bits wide, so NUM_WORDS=2^ADDR_W is representable.
- A readdatavalid arriving in IDLE, WRITE or DONE is ignored and is not counted.
- Reset asserted mid-pass aborts the pass immediately and restores all reset values. Outstanding read returns after reset are ignored because the FSM is in IDLE.
- Latency: the first mem_write asserts 1 cycle after the accepted start. done follows the last readdatavalid by 1 cycle.

Optional Feature:
- Macro: SDRAM_TEST_ERR_INJECT_EN.
- When defined: add input err_inject (1 bit, sampled with start). If it is set, bit 0 of the write data for the first word of the pass is inverted. The first read-back therefore mismatches, giving a bench and board self-check of the compare path.
- When undefined: the port and its logic are absent, and write data is always the raw LFSR value.

Decomposition:
- Package sdram_test_pkg:
  - state enum (IDLE, WRITE, READ, DRAIN, DONE);
  - function lfsr8_next(byte) implementing the step above;
  - constant LFSR_W=8.
- One sub-module is natural: sdram_test_lfsr8, with controls clk, reset, reload, step and output data, instantiated twice (gen and chk). It uses the synchronous active-high reset.

Test Plan:
- NUM_WORDS=4, SEED=32, zero-wait memory model, start pulse -> writes 0x20, 0x40, 0x80, 0x1D at addresses 0..3; reads return the same; done pulses; pass=1, err_count=0.
- Random mem_waitrequest at 50% -> each write/read request and its address/data are held stable while stalled; still exactly NUM_WORDS accepted writes and reads; pass=1.
- Memory model corrupts the word at address 2 (returns 0x81 instead of 0x80) -> pass=0, err_count=1, first_err_addr=2.
- Model returns all zeros with ERR_W=2, NUM_WORDS=8 -> err_count saturates at 3; pass=0; first_err_addr=0.
- reset asserted during READ with 3 reads outstanding -> all outputs reach reset values the next cycle; late readdatavalid pulses are ignored; a following start runs a clean pass with pass=1.
- With SDRAM_TEST_ERR_INJECT_EN defined and err_inject=1 -> first write data is 0x21; pass=0, err_count=1, first_err_addr=BASE_ADDR.
